// File: rtl/div_stall_unit_if.sv
// ---------------------------------------------------------------------------
// div_stall_unit_if
//   Bundles the execute-stage request, the divider result and the stall
//   request of div_stall_unit.
//
//   start_i       EX -> div  division request, held high while stalled
//   annul_i       EX -> div  abort the division in flight (flush)
//   signed_div_i  EX -> div  1 = DIV (signed), 0 = DIVU (unsigned)
//   opdata1_i     EX -> div  dividend
//   opdata2_i     EX -> div  divisor
//   result_o      div -> EX  {remainder, quotient}, registered
//   ready_o       div -> EX  result valid, registered
//   stallreq_o    div -> ctl stall request, combinational
//
//   master: the execute stage / bench side.  slave: the divider.
// ---------------------------------------------------------------------------
interface div_stall_unit_if #(
    parameter int WIDTH = 32
);
    logic                 start_i;
    logic                 annul_i;
    logic                 signed_div_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;
    logic                 stallreq_o;

    modport master (
        output start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
        input  result_o, ready_o, stallreq_o
    );

    modport slave (
        input  start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
        output result_o, ready_o, stallreq_o
    );
endinterface

// File: rtl/div_stall_unit.sv
// ---------------------------------------------------------------------------
// div_stall_unit
//   Multi-cycle restoring divider for DIV / DIVU in the execute stage.
//   While a division is in flight it requests a pipeline stall, which keeps
//   start_i and the operands stable until ready_o rises.
//   Result layout: result_o = {HI = remainder, LO = quotient}.
//
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   div_stall_unit_if.slave (start_i, annul_i, signed_div_i,
//         opdata1_i, opdata2_i -> result_o, ready_o, stallreq_o)
//
//   Latency: divisor != 0 -> ready_o after the 33rd edge counting the edge
//   that samples start_i; divisor == 0 -> ready_o after the 2nd edge.
// ---------------------------------------------------------------------------
module div_stall_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    div_stall_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        S_FREE,
        S_BYZERO,
        S_ON,
        S_END
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     rem_q, rem_d;      // partial remainder
    logic [WIDTH-1:0]     quo_q, quo_d;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]     dvs_q, dvs_d;      // latched divisor magnitude
    logic                 neg_quo_q, neg_quo_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 ready_q, ready_d;

    // One restoring step: shift the next dividend bit into the remainder and
    // trial-subtract. The remainder is always below the divisor, so the
    // shifted value fits WIDTH+1 bits and an accepted difference fits WIDTH.
    logic [WIDTH:0]       shifted;
    logic                 take;
    logic [WIDTH-1:0]     step_rem;
    logic [WIDTH-1:0]     step_quo;
    logic [WIDTH-1:0]     fix_rem;
    logic [WIDTH-1:0]     fix_quo;

    assign shifted  = {rem_q, quo_q[WIDTH-1]};
    assign take     = (shifted >= {1'b0, dvs_q});
    assign step_rem = take ? (shifted[WIDTH-1:0] - dvs_q) : shifted[WIDTH-1:0];
    assign step_quo = {quo_q[WIDTH-2:0], take};
    assign fix_quo  = neg_quo_q ? (~step_quo + 1'b1) : step_quo;
    assign fix_rem  = neg_rem_q ? (~step_rem + 1'b1) : step_rem;

    // Magnitudes for signed mode; abs of the most negative value wraps to
    // itself, which is exactly the unsigned magnitude we need.
    logic                 op1_neg, op2_neg;
    logic [WIDTH-1:0]     op1_mag, op2_mag;

    assign op1_neg = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
    assign op2_neg = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
    assign op1_mag = op1_neg ? (~bus.opdata1_i + 1'b1) : bus.opdata1_i;
    assign op2_mag = op2_neg ? (~bus.opdata2_i + 1'b1) : bus.opdata2_i;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = ready_q;

        unique case (state_q)
            S_FREE: begin
                result_d = '0;
                ready_d  = 1'b0;
                if (bus.start_i && !bus.annul_i) begin
                    if (bus.opdata2_i == '0) begin
                        state_d = S_BYZERO;
                    end else begin
                        state_d   = S_ON;
                        cnt_d     = '0;
                        rem_d     = '0;
                        quo_d     = op1_mag;
                        dvs_d     = op2_mag;
                        neg_quo_d = op1_neg ^ op2_neg;
                        neg_rem_d = op1_neg;
                    end
                end
            end

            S_BYZERO: begin
                result_d = '0;
                if (bus.annul_i) begin
                    state_d = S_FREE;
                    ready_d = 1'b0;
                end else begin
                    state_d = S_END;
                    ready_d = 1'b1;
                end
            end

            S_ON: begin
                if (bus.annul_i) begin
                    state_d  = S_FREE;
                    cnt_d    = '0;
                    result_d = '0;
                    ready_d  = 1'b0;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d  = S_END;
                        cnt_d    = '0;
                        result_d = {fix_rem, fix_quo};
                        ready_d  = 1'b1;
                    end
                end
            end

            S_END: begin
                // Holding start_i keeps the result; it never re-launches.
                if (!bus.start_i || bus.annul_i) begin
                    state_d  = S_FREE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end
            end

            default: begin
                state_d  = S_FREE;
                result_d = '0;
                ready_d  = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FREE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign bus.result_o   = result_q;
    assign bus.ready_o    = ready_q;
    // Combinational so the stall controller freezes the pipe in the same cycle.
    assign bus.stallreq_o = bus.start_i & ~bus.annul_i & ~ready_q;

endmodule

// File: tb/tb_div_stall_unit.sv
// ---------------------------------------------------------------------------
// tb_div_stall_unit
//   Directed and randomized checks of div_stall_unit: results, latency,
//   stall-request duration, annul, reset mid-division, divide by zero.
// ---------------------------------------------------------------------------
module tb_div_stall_unit;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    div_stall_unit_if #(.WIDTH(W)) bus ();

    div_stall_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit signed arithmetic (truncating division), so
    // 0x80000000 / -1 cannot overflow; results are taken modulo 2^32.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic drive(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.annul_i      = 1'b0;
        bus.start_i      = 1'b1;
    endtask

    // Called at a negedge with start_i already high. Counts edges until
    // ready_o and cycles with stallreq_o, then optionally holds start_i in
    // END before dropping it.
    task automatic run_to_done(input string tag, input logic [63:0] exp_res,
                               input int exp_lat, input int hold, input bit scramble);
        int edges  = 0;
        int stalls = 0;
        while (bus.ready_o !== 1'b1 && edges < 100) begin
            #1;
            if (bus.stallreq_o === 1'b1) stalls++;
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (scramble) begin
                bus.opdata1_i = $urandom;
                bus.opdata2_i = $urandom;
            end
        end
        check({tag, "_latency"}, 64'(edges), 64'(exp_lat));
        check({tag, "_stall_cycles"}, 64'(stalls), 64'(exp_lat));
        check({tag, "_result"}, bus.result_o, exp_res);
        check({tag, "_stall_low_at_ready"}, 64'(bus.stallreq_o), 64'd0);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, "_hold_ready"}, 64'(bus.ready_o), 64'd1);
            check({tag, "_hold_result"}, bus.result_o, exp_res);
        end
        bus.start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_drop_ready"}, 64'(bus.ready_o), 64'd0);
        check({tag, "_drop_result"}, bus.result_o, 64'd0);
    endtask

    initial begin
        logic        sgn;
        logic [31:0] a, b;
        bit          rose;

        rst              = 1'b1;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ready", 64'(bus.ready_o), 64'd0);
        check("reset_result", bus.result_o, 64'd0);
        check("reset_stallreq", 64'(bus.stallreq_o), 64'd0);
        rst = 1'b0;

        // Unsigned 100/7, start held two cycles into END.
        drive(1'b0, 32'd100, 32'd7);
        run_to_done("u100_7", {32'd2, 32'd14}, 33, 2, 1'b0);

        // Signed sign handling.
        drive(1'b1, 32'hFFFF_FFF9, 32'd2);
        run_to_done("s_m7_2", {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 0, 1'b0);
        drive(1'b1, 32'd7, 32'hFFFF_FFFE);
        run_to_done("s_7_m2", {32'h0000_0001, 32'hFFFF_FFFD}, 33, 0, 1'b0);

        // Divide by zero in both modes.
        drive(1'b0, 32'd5, 32'd0);
        run_to_done("u5_0", 64'd0, 2, 1, 1'b0);
        drive(1'b1, 32'd5, 32'd0);
        run_to_done("s5_0", 64'd0, 2, 0, 1'b0);

        // Edge values.
        drive(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_to_done("s_min_m1", {32'd0, 32'h8000_0000}, 33, 0, 1'b0);
        drive(1'b0, 32'hFFFF_FFFF, 32'd1);
        run_to_done("u_max_1", {32'd0, 32'hFFFF_FFFF}, 33, 0, 1'b0);
        drive(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_to_done("u_max_max", {32'd0, 32'd1}, 33, 0, 1'b0);

        // Operands scrambled after start must not matter: -1000/7 = -142 r -6.
        drive(1'b1, 32'hFFFF_FC18, 32'd7);
        run_to_done("s_scramble", {32'hFFFF_FFFA, 32'hFFFF_FF72}, 33, 0, 1'b1);

        // Annul around step 10 of ON.
        drive(1'b0, 32'd100, 32'd7);
        repeat (11) @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b1;
        #1;
        check("annul_stall_low", 64'(bus.stallreq_o), 64'd0);
        @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        check("annul_ready", 64'(bus.ready_o), 64'd0);
        check("annul_result", bus.result_o, 64'd0);
        rose = 1'b0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.ready_o !== 1'b0) rose = 1'b1;
        end
        check("annul_ready_never_rises", 64'(rose), 64'd0);
        drive(1'b0, 32'd9, 32'd3);
        run_to_done("after_annul_9_3", {32'd0, 32'd3}, 33, 0, 1'b0);

        // Annul while in BYZERO.
        drive(1'b0, 32'd5, 32'd0);
        @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        check("annul_byzero_ready", 64'(bus.ready_o), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("annul_byzero_ready_later", 64'(bus.ready_o), 64'd0);

        // Reset around step 20; start held across it restarts from scratch.
        drive(1'b0, 32'd123456, 32'd789);
        repeat (21) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_ready", 64'(bus.ready_o), 64'd0);
        check("midrst_result", bus.result_o, 64'd0);
        rst = 1'b0;
        run_to_done("after_rst", ref_div(1'b0, 32'd123456, 32'd789), 33, 0, 1'b0);

        // Randomized operands against the reference model.
        for (int i = 0; i < 12; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'($urandom_range(0, 3));
                1:       b = 32'($urandom_range(1, 1000));
                2:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 1000));
                default: b = $urandom;
            endcase
            drive(sgn, a, b);
            run_to_done($sformatf("rand%0d", i), ref_div(sgn, a, b),
                        (b == 32'd0) ? 2 : 33, 0, (i % 2) == 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
